// File: rtl/delay_pkg.sv
// Shared types and helpers for the credit-wrapped delay line.
package delay_pkg;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } dcb_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/delay_fifo_sync.sv
// Synchronous output FIFO: registered array, head read combinationally, no bypass.
// Simultaneous push and pop are allowed at any occupancy.
module delay_fifo_sync
  import delay_pkg::*;
#(
  parameter int SW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                      Ck,
  input  logic                      Rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [SW-1:0]             din,
  output logic [SW-1:0]             dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/delay_credit_buf.sv
// Credit-based ready/valid wrapper around a free-running fixed-latency Delay line.
// Optional sticky DN-mismatch checker on Err is enabled by DELAY_CREDIT_ERR_CHK_EN.
module delay_credit_buf
  import delay_pkg::*;
#(
  parameter int SW    = 8,
  parameter int DN    = 6,
  parameter int DEPTH = 8
) (
  input  logic          Ck,
  input  logic          Rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [SW-1:0] s_data,
  output logic [SW:0]   dly_di,
  input  logic [SW:0]   dly_do,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [SW-1:0] m_data,
  output logic          Err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int FW = cnt_w(DN);

  dcb_state_t    state, state_nxt;
  logic [FW-1:0] flush_cnt, flush_nxt;
  logic [CW-1:0] cred;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          acc;
  logic          pop;
  logic          push;

  assign s_ready = (state == RUN) & (cred != '0);
  assign acc     = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign dly_di  = {acc, s_data};
  // The delay line has no reset: tags seen while flushing are stale.
  assign push    = (state == RUN) & dly_do[SW];
  assign m_valid = (fifo_count != '0);

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= FLUSH;
      flush_cnt <= FW'(DN);
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    case (state)
      FLUSH: begin
        flush_nxt = flush_cnt - 1'b1;
        if (flush_cnt == FW'(1)) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      cred <= CW'(DEPTH);
    end else if (acc & ~pop) begin
      cred <= cred - 1'b1;
    end else if (pop & ~acc) begin
      cred <= cred + 1'b1;
    end
  end

  delay_fifo_sync #(
    .SW    (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Ck    (Ck),
    .Rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .din   (dly_do[SW-1:0]),
    .dout  (m_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  logic flags_unused;

`ifdef DELAY_CREDIT_ERR_CHK_EN
  logic err_q;

  assign flags_unused = fifo_empty;

  // Overflow or a tag with no outstanding credit both mean DN is wrong.
  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      err_q <= 1'b0;
    end else if ((push & fifo_full & ~pop) | (push & (cred == CW'(DEPTH)))) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign flags_unused = fifo_empty | fifo_full;
  assign Err          = 1'b0;
`endif

endmodule

// File: tb/tb_delay_credit_buf.sv
// Bench for delay_credit_buf: table vectors, stream/latency and reset sequences, random run vs queue model.
module tb_delay_credit_buf;

  localparam int SW    = 8;
  localparam int DN    = 6;
  localparam int DEPTH = 8;

  logic          Ck = 1'b0;
  logic          Rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_data = '0;
  logic [SW:0]   dly_di;
  logic [SW:0]   dly_do;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [SW-1:0] m_data;
  logic          Err;

  delay_credit_buf #(.SW(SW), .DN(DN), .DEPTH(DEPTH)) dut (
    .Ck      (Ck),
    .Rst_n   (Rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .dly_di  (dly_di),
    .dly_do  (dly_do),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .Err     (Err)
  );

  always #5 Ck = ~Ck;

  // Behavioural Delay line with an override for injecting stray tags.
  logic [SW:0] pipe [DN];
  logic        inj_en = 1'b0;
  logic [SW:0] inj_val = '0;

  always @(posedge Ck) begin
    pipe[0] <= dly_di;
    for (int i = 1; i < DN; i++) pipe[i] <= pipe[i-1];
  end
  assign dly_do = inj_en ? inj_val : pipe[DN-1];

  typedef struct {
    int            t;
    logic [SW-1:0] d;
  } ent_t;

  typedef struct {
    logic          sv;
    logic [SW-1:0] sd;
    logic          mr;
    logic          srdy;
    logic          mval;
    logic [SW-1:0] mdata;
  } vec_t;

  ent_t          mq[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic          mdl_en = 1'b1;
  logic          got_srdy, got_mval, got_err;
  logic [SW-1:0] got_mdata;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // One clock: model accepts while fewer than DEPTH samples are outstanding after
  // the DN-cycle flush; a sample accepted at t is poppable from t+DN+1 onward.
  task automatic step(input logic sv, input logic [SW-1:0] sd, input logic mr);
    logic e_srdy, e_mval;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    got_srdy  = s_ready;
    got_mval  = m_valid;
    got_mdata = m_data;
    got_err   = Err;
    if (mdl_en) begin
      e_srdy = (cyc >= DN) && (mq.size() < DEPTH);
      e_mval = (mq.size() != 0) && (mq[0].t + DN + 1 <= cyc);
      chk("s_ready", s_ready, e_srdy);
      chk("m_valid", m_valid, e_mval);
      if (e_mval) chk("m_data", m_data, mq[0].d);
      chk("dly_di", dly_di, {sv & e_srdy, sd});
      chk("err", Err, 0);
      if (sv && e_srdy) mq.push_back('{cyc, sd});
      if (e_mval && mr) void'(mq.pop_front());
    end
    @(posedge Ck);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = 8'h5A;
    inj_en  = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_dly_di", dly_di, {1'b0, 8'h5A});
    chk("rst_err", Err, 0);
    @(posedge Ck);
    #1;
    Rst_n = 1'b1;
    cyc   = 0;
    mq.delete();
  endtask

  vec_t tbl[35];

  initial begin
    int acc0, out0, nout, gaps, srdy_low, order_bad, expn, c, pv, pm;

    for (int i = 0; i < 35; i++) begin
      if (i < DN) begin
        tbl[i] = '{1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 8'h00};
      end else if (i < DN + 20) begin
        tbl[i] = '{1'b1, 8'(8'h40 + i - DN), 1'b0, (i - DN) < DEPTH, (i - DN) >= DN + 1, 8'h40};
      end else if (i < DN + 20 + DEPTH) begin
        tbl[i] = '{1'b0, 8'h00, 1'b1, (i - DN - 20) >= 1, 1'b1, 8'(8'h40 + i - DN - 20)};
      end else begin
        tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      end
    end

    @(posedge Ck);
    #1;
    do_reset();

    // Flush with random stray tags, then fill with m_ready low, then drain.
    for (int i = 0; i < 35; i++) begin
      inj_en  = (i < DN);
      inj_val = {1'b1, 8'($urandom)};
      step(tbl[i].sv, tbl[i].sd, tbl[i].mr);
      chk($sformatf("tbl%0d_s_ready", i), got_srdy, tbl[i].srdy);
      chk($sformatf("tbl%0d_m_valid", i), got_mval, tbl[i].mval);
      if (tbl[i].mval) chk($sformatf("tbl%0d_m_data", i), got_mdata, tbl[i].mdata);
    end
    inj_en = 1'b0;

    // Full-rate stream 0x01..0x20 with m_ready high.
    acc0 = -1; out0 = -1; nout = 0; gaps = 0; srdy_low = 0; order_bad = 0; expn = 1;
    for (int n = 1; n <= 32 + DN + 4; n++) begin
      c = cyc;
      step(n <= 32, 8'(n), 1'b1);
      if (n == 1 && got_srdy) acc0 = c;
      if (n <= 32 && !got_srdy) srdy_low++;
      if (got_mval) begin
        if (out0 < 0) out0 = c;
        if (got_mdata != 8'(expn)) order_bad++;
        expn++;
        nout++;
      end else if (out0 >= 0 && nout < 32) begin
        gaps++;
      end
    end
    chk("stream_latency", out0 - acc0, DN + 1);
    chk("stream_count", nout, 32);
    chk("stream_gaps", gaps, 0);
    chk("stream_s_ready_low", srdy_low, 0);
    chk("stream_order", order_bad, 0);

    // Random traffic with shifting duty cycles.
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 3)
        0:       begin pv = 30; pm = 90; end
        1:       begin pv = 95; pm = 50; end
        default: begin pv = 60; pm = 20; end
      endcase
      step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pm);
    end

    // Reset with 5 samples in flight and 3 in the FIFO.
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("mid_s_ready_exhausted", got_srdy, 0);
    chk("mid_fifo_holds", got_mval, 1);
    do_reset();
    for (int i = 0; i < DN + 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("post_rst_discarded", got_mval, 0);
    chk("post_rst_s_ready", got_srdy, 1);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);

`ifdef DELAY_CREDIT_ERR_CHK_EN
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    mdl_en  = 1'b0;
    inj_en  = 1'b1;
    inj_val = {1'b1, 8'h77};
    step(1'b0, 8'h00, 1'b0);
    chk("err_before", got_err, 0);
    inj_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("err_sticky", got_err, 1);
    end
    do_reset();
    mdl_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
